bisr_weight_remap_ctrl: RTL and testbench

- Next-generation BISR weight allocator for the systolic array. Supports rectangular arrays (ROWS x COLS) and accepts weights over a valid/ready stream.
- Uses a fault-aware, priority-based assignment: each logical weight row goes to a compatible physical row, with partially faulty rows preferred over fault-free ones.
- Sits between the weight loader and the systolic array. Serves remapped weights, physical address and PE-disable mask to the array and activation memory.

---
 rtl/bisr_weight_remap_ctrl.sv | 176 +++++++++++++++++
 tb/tb_bisr_weight_remap_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bisr_weight_remap_ctrl.sv
// Fault-aware weight row allocator: places each logical weight row on a compatible physical row
// (partially faulty rows first) and serves remapped weights, physical address and PE mask on read.
module bisr_weight_remap_ctrl #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ADDR_WIDTH   = $clog2(ROWS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         envm_wr_en,
    input  logic [ROWS*COLS-1:0]         envm_fault_map,
    input  logic                         alloc_start,
    input  logic [COLS*WEIGHT_WIDTH-1:0] w_data,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic                         rd_valid,
    output logic [COLS*WEIGHT_WIDTH-1:0] rd_weights,
    output logic [ADDR_WIDTH-1:0]        rd_phys_addr,
    output logic [COLS-1:0]              rd_pe_disable,
    output logic                         alloc_busy,
    output logic                         alloc_done,
    output logic                         alloc_success,
    output logic [ADDR_WIDTH-1:0]        fail_row
);

    localparam int RowW = COLS * WEIGHT_WIDTH;

    typedef enum logic [1:0] {StIdle, StLoad, StDone, StFail} state_e;

    state_e state_q, state_d;

    logic [ROWS*COLS-1:0]  fault_map;
    logic [ROWS-1:0]       used;
    logic [ADDR_WIDTH-1:0] map_tbl [ROWS];
    logic [RowW-1:0]       storage [ROWS];
    logic [ADDR_WIDTH:0]   row_cnt;

    logic [COLS-1:0]       fault_row [ROWS];
    logic [COLS-1:0]       zero_mask;
    logic [ROWS-1:0]       compat;
    logic                  found_faulty, found_clean, found;
    logic [ADDR_WIDTH-1:0] pick_faulty, pick_clean, pick;
    logic                  map_wr, start_go, xfer, last_row;
    logic                  addr_ok;
    logic [ADDR_WIDTH-1:0] rd_idx, rd_map;

    always_comb begin
        for (int p = 0; p < ROWS; p++) begin
            fault_row[p] = fault_map[p*COLS +: COLS];
        end
    end

    always_comb begin
        zero_mask = '0;
        for (int c = 0; c < COLS; c++) begin
            zero_mask[c] = (w_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0);
        end
    end

    // Descending scan so the lowest-index candidate of each class wins.
    always_comb begin
        compat       = '0;
        found_faulty = 1'b0;
        found_clean  = 1'b0;
        pick_faulty  = '0;
        pick_clean   = '0;
        for (int p = ROWS - 1; p >= 0; p--) begin
            compat[p] = !used[p] && ((fault_row[p] & ~zero_mask) == '0);
            if (compat[p] && (fault_row[p] != '0)) begin
                found_faulty = 1'b1;
                pick_faulty  = ADDR_WIDTH'(p);
            end
            if (compat[p] && (fault_row[p] == '0)) begin
                found_clean = 1'b1;
                pick_clean  = ADDR_WIDTH'(p);
            end
        end
        found = found_faulty || found_clean;
        pick  = found_faulty ? pick_faulty : pick_clean;
    end

    // A map write outside LOAD takes precedence over a simultaneous start.
    assign map_wr   = envm_wr_en && (state_q != StLoad);
    assign start_go = alloc_start && !map_wr;
    assign xfer     = w_valid && (state_q == StLoad) && !start_go;
    assign last_row = (row_cnt == (ADDR_WIDTH+1)'(ROWS - 1));

    assign addr_ok = ({1'b0, rd_addr} < (ADDR_WIDTH+1)'(ROWS));
    assign rd_idx  = addr_ok ? rd_addr : '0;
    assign rd_map  = map_tbl[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (map_wr) begin
            state_d = StIdle;
        end else if (start_go) begin
            state_d = StLoad;
        end else if (xfer) begin
            if (!found) begin
                state_d = StFail;
            end else if (last_row) begin
                state_d = StDone;
            end
        end
    end

    always_comb begin
        w_ready    = (state_q == StLoad);
        alloc_busy = (state_q == StLoad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_map     <= '0;
            used          <= '0;
            row_cnt       <= '0;
            alloc_done    <= 1'b0;
            alloc_success <= 1'b0;
            fail_row      <= '0;
            rd_valid      <= 1'b0;
            rd_weights    <= '0;
            rd_phys_addr  <= '0;
            rd_pe_disable <= '0;
            for (int p = 0; p < ROWS; p++) begin
                map_tbl[p] <= '0;
                storage[p] <= '0;
            end
        end else begin
            if (map_wr) begin
                fault_map     <= envm_fault_map;
                alloc_done    <= 1'b0;
                alloc_success <= 1'b0;
            end else if (start_go) begin
                row_cnt       <= '0;
                used          <= '0;
                alloc_done    <= 1'b0;
                alloc_success <= 1'b0;
                fail_row      <= '0;
            end else if (xfer) begin
                if (found) begin
                    storage[pick]                       <= w_data;
                    map_tbl[row_cnt[ADDR_WIDTH-1:0]]    <= pick;
                    used[pick]                          <= 1'b1;
                    row_cnt                             <= row_cnt + 1'b1;
                    if (last_row) begin
                        alloc_done    <= 1'b1;
                        alloc_success <= 1'b1;
                    end
                end else begin
                    fail_row      <= row_cnt[ADDR_WIDTH-1:0];
                    alloc_done    <= 1'b1;
                    alloc_success <= 1'b0;
                end
            end

            rd_valid <= rd_en && (state_q == StDone) && addr_ok;
            if (rd_en && (state_q == StDone) && addr_ok) begin
                rd_phys_addr  <= rd_map;
                rd_weights    <= storage[rd_map];
                rd_pe_disable <= fault_row[rd_map];
            end
        end
    end

endmodule

// File: tb/tb_bisr_weight_remap_ctrl.sv
// Directed bench for bisr_weight_remap_ctrl: identity, fault-aware placement, failure,
// handshake gaps, restart, LOAD-time map-write rejection and asynchronous reset.
module tb_bisr_weight_remap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        envm_wr_en = 1'b0;
    logic [63:0] envm_fault_map = '0;
    logic        alloc_start = 1'b0;
    logic [63:0] w_data = '0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic        rd_en = 1'b0;
    logic [2:0]  rd_addr = '0;
    logic        rd_valid;
    logic [63:0] rd_weights;
    logic [2:0]  rd_phys_addr;
    logic [7:0]  rd_pe_disable;
    logic        alloc_busy;
    logic        alloc_done;
    logic        alloc_success;
    logic [2:0]  fail_row;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] rows [8];

    bisr_weight_remap_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .envm_wr_en    (envm_wr_en),
        .envm_fault_map(envm_fault_map),
        .alloc_start   (alloc_start),
        .w_data        (w_data),
        .w_valid       (w_valid),
        .w_ready       (w_ready),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_weights    (rd_weights),
        .rd_phys_addr  (rd_phys_addr),
        .rd_pe_disable (rd_pe_disable),
        .alloc_busy    (alloc_busy),
        .alloc_done    (alloc_done),
        .alloc_success (alloc_success),
        .fail_row      (fail_row)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input int r, input logic [7:0] seed);
        logic [63:0] v;
        for (int c = 0; c < 8; c++) v[c*8 +: 8] = seed + 8'(r * 16 + c + 1);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_map(input logic [63:0] m);
        envm_fault_map = m;
        envm_wr_en = 1'b1;
        tick();
        envm_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        alloc_start = 1'b1;
        tick();
        alloc_start = 1'b0;
    endtask

    task automatic send_row(input logic [63:0] d);
        w_data = d;
        w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
    endtask

    task automatic read_row(input logic [2:0] a);
        rd_addr = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({w_ready, alloc_busy, alloc_done, alloc_success, rd_valid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 00000",
                     {w_ready, alloc_busy, alloc_done, alloc_success, rd_valid});
        end
        vectors++;
        if ({rd_weights, rd_phys_addr, rd_pe_disable, fail_row} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0",
                     {rd_weights, rd_phys_addr, rd_pe_disable, fail_row});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_identity();
        load_map(64'h0);
        pulse_start();
        vectors++;
        if ({alloc_busy, w_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL id_load_entry: got %b want 11", {alloc_busy, w_ready});
        end
        for (int r = 0; r < 8; r++) begin
            rows[r] = mk(r, 8'h10);
            if (r == 7) begin
                vectors++;
                if (alloc_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL id_done_early: got %b want 0", alloc_done);
                end
            end
            send_row(rows[r]);
        end
        vectors++;
        if ({alloc_done, alloc_success, w_ready, alloc_busy} !== 4'b1100) begin
            miscompares++;
            $display("FAIL id_done: got %b want 1100",
                     {alloc_done, alloc_success, w_ready, alloc_busy});
        end
        read_row(3'd5);
        vectors++;
        if ({rd_valid, rd_phys_addr, rd_pe_disable} !== {1'b1, 3'd5, 8'h00}) begin
            miscompares++;
            $display("FAIL id_read5: got %b/%0d/%h want 1/5/00",
                     rd_valid, rd_phys_addr, rd_pe_disable);
        end
        vectors++;
        if (rd_weights !== rows[5]) begin
            miscompares++;
            $display("FAIL id_read5_w: got %h want %h", rd_weights, rows[5]);
        end
        tick();
        vectors++;
        if ({rd_valid, rd_phys_addr} !== {1'b0, 3'd5}) begin
            miscompares++;
            $display("FAIL id_hold: got %b/%0d want 0/5", rd_valid, rd_phys_addr);
        end
    endtask

    task automatic test_partial_fault();
        logic [2:0] exp_phys [8];
        exp_phys = '{3'd2, 3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        load_map(64'h1 << 19);
        vectors++;
        if ({alloc_done, alloc_success, alloc_busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL pf_mapwr_clear: got %b want 000",
                     {alloc_done, alloc_success, alloc_busy});
        end
        pulse_start();
        for (int r = 0; r < 8; r++) begin
            rows[r] = mk(r, 8'h20);
            if (r == 0) rows[r][31:24] = 8'h00;
            send_row(rows[r]);
        end
        vectors++;
        if (alloc_success !== 1'b1) begin
            miscompares++;
            $display("FAIL pf_success: got %b want 1", alloc_success);
        end
        rd_en = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            tick();
            vectors++;
            if ({rd_valid, rd_phys_addr, rd_pe_disable, rd_weights} !==
                {1'b1, exp_phys[a], (a == 0) ? 8'h08 : 8'h00, rows[a]}) begin
                miscompares++;
                $display("FAIL pf_read%0d: got %b/%0d/%h/%h want 1/%0d/%h/%h", a,
                         rd_valid, rd_phys_addr, rd_pe_disable, rd_weights,
                         exp_phys[a], (a == 0) ? 8'h08 : 8'h00, rows[a]);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_fail();
        load_map(64'h1 << 32);
        pulse_start();
        for (int r = 0; r < 8; r++) begin
            rows[r] = mk(r, 8'h30);
            vectors++;
            if (w_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL fl_ready_r%0d: got %b want 1", r, w_ready);
            end
            send_row(rows[r]);
        end
        vectors++;
        if ({w_ready, alloc_done, alloc_success, alloc_busy} !== 4'b0100) begin
            miscompares++;
            $display("FAIL fl_flags: got %b want 0100",
                     {w_ready, alloc_done, alloc_success, alloc_busy});
        end
        vectors++;
        if (fail_row !== 3'd7) begin
            miscompares++;
            $display("FAIL fl_fail_row: got %0d want 7", fail_row);
        end
        read_row(3'd0);
        vectors++;
        if ({rd_valid, rd_phys_addr} !== {1'b0, 3'd7}) begin
            miscompares++;
            $display("FAIL fl_read_blocked: got %b/%0d want 0/7", rd_valid, rd_phys_addr);
        end
    endtask

    task automatic test_valid_toggle();
        load_map(64'h0);
        pulse_start();
        for (int r = 0; r < 8; r++) rows[r] = mk(r, 8'h40);
        for (int i = 0; i < 16; i++) begin
            w_valid = ~i[0];
            w_data  = i[0] ? 64'hFFFF_FFFF_FFFF_FFFF : rows[i / 2];
            tick();
            if (i == 13) begin
                vectors++;
                if ({alloc_done, w_ready} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL vt_after7: got %b want 01", {alloc_done, w_ready});
                end
            end
        end
        w_valid = 1'b0;
        vectors++;
        if ({alloc_done, alloc_success} !== 2'b11) begin
            miscompares++;
            $display("FAIL vt_done: got %b want 11", {alloc_done, alloc_success});
        end
        read_row(3'd3);
        vectors++;
        if ({rd_valid, rd_phys_addr, rd_weights} !== {1'b1, 3'd3, rows[3]}) begin
            miscompares++;
            $display("FAIL vt_read3: got %b/%0d/%h want 1/3/%h",
                     rd_valid, rd_phys_addr, rd_weights, rows[3]);
        end
    endtask

    task automatic test_restart();
        pulse_start();
        for (int r = 0; r < 3; r++) send_row(mk(r, 8'h50));
        pulse_start();
        vectors++;
        if ({alloc_busy, alloc_done} !== 2'b10) begin
            miscompares++;
            $display("FAIL rs_restart: got %b want 10", {alloc_busy, alloc_done});
        end
        for (int r = 0; r < 8; r++) begin
            rows[r] = mk(r, 8'h60);
            send_row(rows[r]);
            if (r == 4) begin
                vectors++;
                if (alloc_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rs_no_early_done: got %b want 0", alloc_done);
                end
            end
        end
        vectors++;
        if ({alloc_done, alloc_success} !== 2'b11) begin
            miscompares++;
            $display("FAIL rs_done: got %b want 11", {alloc_done, alloc_success});
        end
        read_row(3'd0);
        vectors++;
        if ({rd_valid, rd_phys_addr, rd_weights} !== {1'b1, 3'd0, rows[0]}) begin
            miscompares++;
            $display("FAIL rs_read0: got %b/%0d/%h want 1/0/%h",
                     rd_valid, rd_phys_addr, rd_weights, rows[0]);
        end
    endtask

    task automatic test_load_mapwr_and_reset();
        pulse_start();
        for (int r = 0; r < 8; r++) rows[r] = mk(r, 8'h70);
        envm_fault_map = 64'hFFFF_FFFF_FFFF_FFFF;
        envm_wr_en = 1'b1;
        send_row(rows[0]);
        envm_wr_en = 1'b0;
        vectors++;
        if ({alloc_busy, w_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL lw_ignored: got %b want 11", {alloc_busy, w_ready});
        end
        for (int r = 1; r < 8; r++) send_row(rows[r]);
        vectors++;
        if ({alloc_done, alloc_success} !== 2'b11) begin
            miscompares++;
            $display("FAIL lw_done: got %b want 11", {alloc_done, alloc_success});
        end
        read_row(3'd6);
        vectors++;
        if ({rd_valid, rd_pe_disable, rd_weights} !== {1'b1, 8'h00, rows[6]}) begin
            miscompares++;
            $display("FAIL lw_map_unchanged: got %b/%h/%h want 1/00/%h",
                     rd_valid, rd_pe_disable, rd_weights, rows[6]);
        end
        pulse_start();
        for (int r = 0; r < 4; r++) send_row(rows[r]);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({w_ready, alloc_busy, alloc_done, alloc_success, rd_valid} !== 5'b0) begin
            miscompares++;
            $display("FAIL mr_flags: got %b want 00000",
                     {w_ready, alloc_busy, alloc_done, alloc_success, rd_valid});
        end
        vectors++;
        if ({rd_weights, rd_phys_addr, rd_pe_disable, fail_row} !== '0) begin
            miscompares++;
            $display("FAIL mr_data: got %h want 0",
                     {rd_weights, rd_phys_addr, rd_pe_disable, fail_row});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({w_ready, alloc_busy, alloc_done} !== 3'b000) begin
            miscompares++;
            $display("FAIL mr_idle: got %b want 000", {w_ready, alloc_busy, alloc_done});
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_partial_fault();
        test_fail();
        test_valid_toggle();
        test_restart();
        test_load_mapwr_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
